// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pad synchronisation, clock deglitching, 11-bit frame
// deframing and a valid/ready byte output with parity, framing and overrun reporting.
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [1:0]    state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          deliver, perr_set, ferr_set, timeout;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // The filtered level only follows the synced clock after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      filt_clk <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_q <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FILT_MAX) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_q & ~filt_clk;

  // Timeout trips on the cycle the counter would reach TIMEOUT_CYCLES-1; a fall always wins.
  always_comb begin
    deliver  = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    timeout  = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE: ferr_set = data_s2;
        S_STOP: begin
          if (!data_s2)               ferr_set = 1'b1;
          else if (^{shreg, par_bit}) deliver  = 1'b1;
          else                        perr_set = 1'b1;
        end
        default: ;
      endcase
    end else if (state != S_IDLE && tcnt == TO_LAST) begin
      timeout  = 1'b1;
      ferr_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= S_IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (state == S_IDLE || fall || timeout) tcnt <= '0;
      else                                    tcnt <= tcnt + 1'b1;

      if (timeout) begin
        state <= S_IDLE;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!data_s2) begin
              state  <= S_DATA;
              bitcnt <= '0;
            end
          end
          S_DATA: begin
            shreg[bitcnt] <= data_s2;
            if (bitcnt == 3'd7) state  <= S_PARITY;
            else                bitcnt <= bitcnt + 1'b1;
          end
          S_PARITY: begin
            par_bit <= data_s2;
            state   <= S_STOP;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // A held byte is never overwritten; a new good byte arriving under backpressure is dropped.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= perr_set;
      frame_err  <= ferr_set;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (deliver && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (clr_overrun)                 overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Randomised scoreboard bench for ps2_rx: a frame-level model queues expected events,
// and an independent monitor pops and compares them as the receiver reports them.
module tb_ps2_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 1000;
  localparam int LAT        = 2 + FILTER_LEN + 1;
  localparam int EV_DATA    = 0;
  localparam int EV_PERR    = 1;
  localparam int EV_FERR    = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       resetb;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       clr_overrun;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   slot_full = 0;
  bit   exp_overrun = 0;
  int   last_fall_cyc = 0;
  int   valid_rise_cyc = 0;
  int   valid_len = 0;
  int   ferr_cyc = 0;
  int   ferr_count = 0;
  int   perr_count = 0;
  logic prev_valid = 1'b0;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic popCheck(input int kind, input logic [7:0] data, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got unexpected event kind %0d data %02h, expected none", name, kind, data);
    end else begin
      e = exp_q.pop_front();
      checkOutput({name, "_kind"}, kind, e.kind);
      if (kind == EV_DATA && e.kind == EV_DATA) checkOutput(name, data, e.data);
    end
  endtask

  // Frame-level reference: decides what one transmitted frame should produce.
  task automatic modelFrame(input logic [7:0] b, input int nbits, input bit bad_par,
                            input bit stop_val, input bit start_val);
    ev_t e;
    e.data = b;
    if (start_val || nbits < 11 || !stop_val) begin
      e.kind = EV_FERR;
      exp_q.push_back(e);
    end else if (bad_par) begin
      e.kind = EV_PERR;
      exp_q.push_back(e);
    end else if (rx_ready || !slot_full) begin
      e.kind = EV_DATA;
      exp_q.push_back(e);
      if (!rx_ready) slot_full = 1;
    end else begin
      exp_overrun = 1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int half, input int nbits,
                               input bit bad_par, input bit stop_val, input bit start_val,
                               input int glitch_bit, input int short_bit, input bit model_on);
    logic [10:0] bits;
    bits = {stop_val, (~^b) ^ bad_par, b, start_val};
    if (model_on) modelFrame(b, nbits, bad_par, stop_val, start_val);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (half / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (half - half / 2 - 2) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat ((i == short_bit) ? FILTER_LEN : half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (half) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (frame_err) begin
        ferr_cyc = cyc;
        ferr_count++;
        popCheck(EV_FERR, 8'h00, "frame_err");
      end
      if (parity_err) begin
        perr_count++;
        popCheck(EV_PERR, 8'h00, "parity_err");
      end
      if (rx_valid && !prev_valid) begin
        valid_rise_cyc = cyc;
        valid_len = 0;
      end
      if (rx_valid) valid_len++;
      if (rx_valid && rx_ready) popCheck(EV_DATA, rx_data, "rx_byte");
      prev_valid = rx_valid;
    end
  end

  initial begin
    int errs0;
    int wait_cyc;
    int kind;
    int half;
    logic [7:0] rb;

    resetb = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    rx_ready = 1'b1;
    clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_parity_err", parity_err, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    resetb = 1'b1;
    repeat (10) @(negedge clk);

    errs0 = ferr_count + perr_count;
    applyStimulus(8'h1C, 40, 11, 0, 1, 0, -1, -1, 1);
    checkOutput("good_latency", valid_rise_cyc - last_fall_cyc, LAT);
    checkOutput("good_valid_len", valid_len, 1);
    checkOutput("good_rx_data", rx_data, 8'h1C);
    checkOutput("good_no_err", ferr_count + perr_count, errs0);

    errs0 = perr_count;
    applyStimulus(8'hF0, 40, 11, 1, 1, 0, -1, -1, 1);
    checkOutput("badpar_pulses", perr_count, errs0 + 1);
    checkOutput("badpar_rx_valid", rx_valid, 0);
    applyStimulus(8'hAA, 40, 11, 0, 1, 0, -1, -1, 1);
    checkOutput("after_badpar_data", rx_data, 8'hAA);

    rx_ready = 1'b0;
    applyStimulus(8'h12, 40, 11, 0, 1, 0, -1, -1, 1);
    applyStimulus(8'h34, 40, 11, 0, 1, 0, -1, -1, 1);
    checkOutput("bp_rx_valid", rx_valid, 1);
    checkOutput("bp_rx_data_held", rx_data, 8'h12);
    checkOutput("bp_overrun", overrun, exp_overrun);
    rx_ready = 1'b1;
    slot_full = 0;
    repeat (2) @(negedge clk);
    checkOutput("bp_valid_drop", rx_valid, 0);
    checkOutput("bp_overrun_sticky", overrun, exp_overrun);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    exp_overrun = 0;
    @(negedge clk);
    checkOutput("bp_overrun_clr", overrun, exp_overrun);
    applyStimulus(8'h56, 40, 11, 0, 1, 0, -1, -1, 1);
    checkOutput("bp_after_data", rx_data, 8'h56);

    errs0 = ferr_count;
    applyStimulus(8'hA5, 40, 5, 0, 1, 0, -1, -1, 1);
    repeat (TIMEOUT + 50) @(negedge clk);
    checkOutput("timeout_pulses", ferr_count, errs0 + 1);
    checkOutput("timeout_latency", ferr_cyc - last_fall_cyc, LAT + TIMEOUT - 1);
    applyStimulus(8'h77, 40, 11, 0, 1, 0, -1, -1, 1);
    checkOutput("after_timeout_data", rx_data, 8'h77);

    applyStimulus(8'h3C, 40, 11, 0, 1, 0, 4, -1, 1);
    checkOutput("glitch_data", rx_data, 8'h3C);
    applyStimulus(8'hC3, 40, 11, 0, 1, 0, -1, 3, 1);
    checkOutput("short_low_data", rx_data, 8'hC3);

    applyStimulus(8'h5A, 40, 5, 0, 1, 0, -1, -1, 0);
    resetb = 1'b0;
    #1;
    checkOutput("areset_rx_data", rx_data, 8'h00);
    checkOutput("areset_rx_valid", rx_valid, 0);
    checkOutput("areset_errs", {parity_err, frame_err, overrun}, 0);
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
    errs0 = ferr_count + perr_count;
    applyStimulus(8'h5A, 40, 11, 0, 1, 0, -1, -1, 1);
    checkOutput("areset_after_data", rx_data, 8'h5A);
    checkOutput("areset_after_no_err", ferr_count + perr_count, errs0);

    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 6);
      half = $urandom_range(12, 50);
      rb = 8'($urandom);
      case (kind)
        0: applyStimulus(rb, half, 11, 1, 1, 0, -1, -1, 1);
        1: applyStimulus(rb, half, 11, 0, 0, 0, -1, -1, 1);
        2: applyStimulus(rb, half, 1, 0, 1, 1, -1, -1, 1);
        3: applyStimulus(rb, half, 11, 1, 0, 0, -1, -1, 1);
        default: applyStimulus(rb, half, 11, 0, 1, 0, -1, -1, 1);
      endcase
      repeat (10) @(negedge clk);
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("final_overrun", overrun, exp_overrun);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
